// File: rtl/alu_result_stage_if.sv
// EX -> result stage -> MEM handshake bundle: EX beat inputs plus the MEM-side skid FIFO head.
interface alu_result_stage_if #(
    parameter int N = 32
);
    logic         ex_valid;
    logic         ex_ready;
    logic [N-1:0] ex_alu_result;
    logic         ex_zero;
    logic [1:0]   ex_branch_op;
    logic [N-1:0] ex_pc_target;
    logic [N-1:0] ex_link;
    logic [4:0]   ex_rd;
    logic         ex_reg_write;

    logic         mem_valid;
    logic         mem_ready;
    logic [N-1:0] mem_result;
    logic [4:0]   mem_rd;
    logic         mem_reg_write;

    modport slave (
        input  ex_valid, ex_alu_result, ex_zero, ex_branch_op, ex_pc_target,
               ex_link, ex_rd, ex_reg_write, mem_ready,
        output ex_ready, mem_valid, mem_result, mem_rd, mem_reg_write
    );

    modport master (
        output ex_valid, ex_alu_result, ex_zero, ex_branch_op, ex_pc_target,
               ex_link, ex_rd, ex_reg_write, mem_ready,
        input  ex_ready, mem_valid, mem_result, mem_rd, mem_reg_write
    );
endinterface

// File: rtl/alu_result_stage.sv
// Resolves beq/bne/jal, pulses a registered PC redirect, squashes wrong-path beats and
// buffers surviving results in a 2-entry FIFO whose head feeds MEM and EX/MEM forwarding.
//
// state  | meaning
// IDLE   | no wrong-path beats pending; accepted beats push, taken branches redirect
// SQUASH | cnt accepted beats still to be discarded after a taken redirect
module alu_result_stage #(
    parameter int N          = 32,
    parameter int SQUASH_CNT = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    alu_result_stage_if.slave    bus,
    output logic                 redirect_valid,
    output logic [N-1:0]         redirect_pc,
    output logic                 squashing
);
    // Counter keeps at least one bit so SQUASH_CNT=0 still elaborates; it then never leaves 0.
    localparam int CW = (SQUASH_CNT > 0) ? $clog2(SQUASH_CNT + 1) : 1;

    typedef enum logic {IDLE, SQUASH} state_t;

    state_t         state, state_next;
    logic [CW-1:0]  cnt, cnt_next;
    logic           redirect_next;
    logic [N-1:0]   pc_next;

    logic           accept, taken, push, pop;
    logic [N-1:0]   push_result;
    logic           push_we;

    logic [1:0]     count;
    logic           wr_ptr, rd_ptr;
    logic [N-1:0]   fifo_result [2];
    logic [4:0]     fifo_rd     [2];
    logic           fifo_we     [2];

    assign bus.ex_ready      = (count != 2'd2);
    assign bus.mem_valid     = (count != 2'd0);
    assign bus.mem_result    = fifo_result[rd_ptr];
    assign bus.mem_rd        = fifo_rd[rd_ptr];
    assign bus.mem_reg_write = fifo_we[rd_ptr];
    assign squashing         = (cnt != '0);

    assign accept = bus.ex_valid & bus.ex_ready;
    assign pop    = bus.mem_valid & bus.mem_ready;
    assign taken  = ((bus.ex_branch_op == 2'b01) &  bus.ex_zero) |
                    ((bus.ex_branch_op == 2'b10) & ~bus.ex_zero) |
                     (bus.ex_branch_op == 2'b11);

    assign push_result = (bus.ex_branch_op == 2'b11) ? bus.ex_link : bus.ex_alu_result;
    assign push_we     = bus.ex_reg_write & (bus.ex_rd != 5'd0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state          <= IDLE;
            cnt            <= '0;
            redirect_valid <= 1'b0;
            redirect_pc    <= '0;
        end else begin
            state          <= state_next;
            cnt            <= cnt_next;
            redirect_valid <= redirect_next;
            redirect_pc    <= pc_next;
        end
    end

    always_comb begin
        cnt_next      = cnt;
        redirect_next = 1'b0;
        pc_next       = redirect_pc;
        push          = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    // Branches only reach the FIFO when they also write rd.
                    push = (bus.ex_branch_op == 2'b00) | (bus.ex_branch_op == 2'b11) |
                           bus.ex_reg_write;
                    if (taken) begin
                        redirect_next = 1'b1;
                        pc_next       = bus.ex_pc_target;
                        cnt_next      = CW'(SQUASH_CNT);
                    end
                end
            end
            SQUASH: begin
                if (accept) cnt_next = cnt - CW'(1);
            end
            default: cnt_next = '0;
        endcase
        state_next = (cnt_next != '0) ? SQUASH : IDLE;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count  <= 2'd0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            for (int i = 0; i < 2; i++) begin
                fifo_result[i] <= '0;
                fifo_rd[i]     <= '0;
                fifo_we[i]     <= 1'b0;
            end
        end else begin
            if (push) begin
                fifo_result[wr_ptr] <= push_result;
                fifo_rd[wr_ptr]     <= bus.ex_rd;
                fifo_we[wr_ptr]     <= push_we;
                wr_ptr              <= ~wr_ptr;
            end
            if (pop) rd_ptr <= ~rd_ptr;
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end
endmodule
